interp_bracket_finder: RTL and testbench

INTERP_BRACKET_FINDER -- requirements
Module: interp_bracket_finder

---
 rtl/interp_bracket_finder_pkg.sv | 13 +
 rtl/interp_bracket_finder_if.sv | 36 +++
 rtl/interp_bracket_finder_sample_table.sv | 49 ++++
 rtl/interp_bracket_finder.sv | 173 +++++++++++++++++
 tb/tb_interp_bracket_finder.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interp_bracket_finder_pkg.sv
// Shared definitions for the interpolator bracket finder: default sizes and FSM state encoding.
package interp_bracket_finder_pkg;

    localparam int IBF_WIDTH = 16;
    localparam int IBF_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/interp_bracket_finder_if.sv
// Table-load, search-request and bracket-result signals between a controller and the bracket finder.
interface interp_bracket_finder_if
    import interp_bracket_finder_pkg::*;
#(
    parameter int WIDTH = IBF_WIDTH,
    parameter int DEPTH = IBF_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clear;
    logic             wr_en;
    logic [WIDTH-1:0] wr_t;
    logic [WIDTH-1:0] wr_u;
    logic             wr_err;
    logic             start;
    logic [WIDTH-1:0] tk;
    logic             busy;
    logic [WIDTH-1:0] tn;
    logic [WIDTH-1:0] un;
    logic [WIDTH-1:0] tz;
    logic [WIDTH-1:0] uz;
    logic             done;
    logic             error;
    logic [CW-1:0]    count;

    modport slave (
        input  clear, wr_en, wr_t, wr_u, start, tk,
        output wr_err, busy, tn, un, tz, uz, done, error, count
    );

    modport master (
        output clear, wr_en, wr_t, wr_u, start, tk,
        input  wr_err, busy, tn, un, tz, uz, done, error, count
    );

endinterface

// File: rtl/interp_bracket_finder_sample_table.sv
// Sample storage: DEPTH (t, u) register pairs, one write port, two combinational read ports.
module sample_table
    import interp_bracket_finder_pkg::*;
#(
    parameter int WIDTH = IBF_WIDTH,
    parameter int DEPTH = IBF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wt,
    input  logic [WIDTH-1:0] wu,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] ta,
    output logic [WIDTH-1:0] ua,
    output logic [WIDTH-1:0] tb,
    output logic [WIDTH-1:0] ub
);

    logic [WIDTH-1:0] t_arr [DEPTH];
    logic [WIDTH-1:0] u_arr [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] t_q;
            logic [WIDTH-1:0] u_q;

            // Contents are don't-care until written; the controller never reads past count.
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    t_q <= wt;
                    u_q <= wu;
                end
            end

            assign t_arr[gi] = t_q;
            assign u_arr[gi] = u_q;
        end
    endgenerate

    assign ta = t_arr[raddr_a];
    assign ua = u_arr[raddr_a];
    assign tb = t_arr[raddr_b];
    assign ub = u_arr[raddr_b];

endmodule

// File: rtl/interp_bracket_finder.sv
// Finds the stored sample pair (t[i], t[i+1]) bracketing a query time, one pair per cycle,
// and hands the pair to the downstream interpolator with a done pulse.
module interp_bracket_finder
    import interp_bracket_finder_pkg::*;
#(
    parameter int WIDTH = IBF_WIDTH,
    parameter int DEPTH = IBF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    interp_bracket_finder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tk_q, tk_d;
    logic             err_q, err_d;
    logic             wr_err_q, wr_err_d;
    logic [WIDTH-1:0] tn_q, tn_d, un_q, un_d, tz_q, tz_d, uz_q, uz_d;

    logic             tbl_we;
    logic [AW-1:0]    last_addr;
    logic [AW-1:0]    rd_addr_a, rd_addr_b;
    logic [WIDTH-1:0] rd_ta, rd_ua, rd_tb, rd_ub;
    logic [WIDTH-1:0] key;
    logic             lo_ok, hi_ok;
    logic             busy;
    logic             append_ok;

    sample_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .we      (tbl_we),
        .waddr   (count_q[AW-1:0]),
        .wt      (bus.wr_t),
        .wu      (bus.wr_u),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .ta      (rd_ta),
        .ua      (rd_ua),
        .tb      (rd_tb),
        .ub      (rd_ub)
    );

    // In IDLE the read ports show t[0] and t[count-1] (range check and append order check);
    // in SCAN they walk the current pair.
    assign last_addr = AW'(count_q - CW'(1));
    assign rd_addr_a = (state_q == ST_SCAN) ? idx_q : '0;
    assign rd_addr_b = (state_q == ST_SCAN) ? idx_q + AW'(1) : last_addr;

    assign key   = (state_q == ST_IDLE) ? bus.tk : tk_q;
    assign lo_ok = $signed(key) >= $signed(rd_ta);
    assign hi_ok = $signed(key) <= $signed(rd_tb);

    assign busy      = (state_q != ST_IDLE);
    assign append_ok = !busy && (count_q < CW'(DEPTH)) &&
                       ((count_q == '0) || ($signed(bus.wr_t) > $signed(rd_tb)));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        tk_d     = tk_q;
        err_d    = err_q;
        wr_err_d = 1'b0;
        tn_d     = tn_q;
        un_d     = un_q;
        tz_d     = tz_q;
        uz_d     = uz_q;
        tbl_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    tk_d  = bus.tk;
                    idx_d = '0;
                    if ((count_q >= CW'(2)) && lo_ok && hi_ok) begin
                        state_d = ST_SCAN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // The range check at start guarantees a hit before idx runs past count-2.
                if (lo_ok && hi_ok) begin
                    tn_d    = rd_ta;
                    un_d    = rd_ua;
                    tz_d    = rd_tb;
                    uz_d    = rd_ub;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.wr_en) begin
            if (append_ok) begin
                tbl_we  = 1'b1;
                count_d = count_q + CW'(1);
            end else begin
                wr_err_d = 1'b1;
            end
        end

        // Flush wins over everything; a pair latched this cycle is discarded too.
        if (bus.clear) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            tbl_we   = 1'b0;
            wr_err_d = 1'b0;
            err_d    = 1'b0;
            tn_d     = tn_q;
            un_d     = un_q;
            tz_d     = tz_q;
            uz_d     = uz_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            tk_q     <= '0;
            err_q    <= 1'b0;
            wr_err_q <= 1'b0;
            tn_q     <= '0;
            un_q     <= '0;
            tz_q     <= '0;
            uz_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            tk_q     <= tk_d;
            err_q    <= err_d;
            wr_err_q <= wr_err_d;
            tn_q     <= tn_d;
            un_q     <= un_d;
            tz_q     <= tz_d;
            uz_q     <= uz_d;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = (state_q == ST_DONE) && !bus.clear;
    assign bus.error  = bus.done && err_q;
    assign bus.wr_err = wr_err_q;
    assign bus.count  = count_q;
    assign bus.tn     = tn_q;
    assign bus.un     = un_q;
    assign bus.tz     = tz_q;
    assign bus.uz     = uz_q;

endmodule

// File: tb/tb_interp_bracket_finder.sv
// Randomized and directed bench for interp_bracket_finder against a queue-based table model.
module tb_interp_bracket_finder;

    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interp_bracket_finder_if #(.WIDTH(W), .DEPTH(D)) bus ();

    interp_bracket_finder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: stored samples in order, plus the last bracket handed downstream.
    logic [W-1:0] mt[$];
    logic [W-1:0] mu[$];
    logic [W-1:0] m_tn = '0, m_un = '0, m_tz = '0, m_uz = '0;

    function automatic int model_pair(input logic [W-1:0] q);
        if (mt.size() < 2) return -1;
        for (int i = 0; i + 1 < mt.size(); i++)
            if ($signed(mt[i]) <= $signed(q) && $signed(q) <= $signed(mt[i+1])) return i;
        return -1;
    endfunction

    function automatic bit model_accept(input logic [W-1:0] t);
        if (mt.size() >= D) return 1'b0;
        if (mt.size() == 0) return 1'b1;
        return $signed(t) > $signed(mt[mt.size()-1]);
    endfunction

    task automatic do_write(input logic [W-1:0] t, input logic [W-1:0] u,
                            output logic werr, output int cnt);
        bus.wr_en = 1'b1; bus.wr_t = t; bus.wr_u = u;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        werr = bus.wr_err;
        cnt  = int'(bus.count);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        mt.delete(); mu.delete();
    endtask

    task automatic do_search(input logic [W-1:0] q, output int lat, output logic err,
                             output logic [W-1:0] otn, output logic [W-1:0] oun,
                             output logic [W-1:0] otz, output logic [W-1:0] ouz,
                             output logic busy_after);
        bus.tk = q; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
        err = bus.error;
        otn = bus.tn; oun = bus.un; otz = bus.tz; ouz = bus.uz;
        @(posedge clk); #1;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.error, bus.wr_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.error, bus.wr_err});
        end
        checks++;
        if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++;
        if ({bus.tn, bus.un, bus.tz, bus.uz} !== 64'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {bus.tn, bus.un, bus.tz, bus.uz});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset released at %0t", $time);
    endtask

    task automatic load_spec_table();
        logic werr; int cnt;
        logic [W-1:0] tv [4] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        logic [W-1:0] uv [4] = '{16'h0000, 16'h0200, 16'h0400, 16'h0600};
        for (int i = 0; i < 4; i++) begin
            do_write(tv[i], uv[i], werr, cnt);
            mt.push_back(tv[i]); mu.push_back(uv[i]);
            checks++;
            if (werr !== 1'b0 || cnt != i + 1) begin
                errors++; $display("FAIL spec_append[%0d] got wr_err=%b count=%0d want 0/%0d", i, werr, cnt, i + 1);
            end
        end
    endtask

    task automatic test_spec_vectors();
        logic [W-1:0] qs [6] = '{16'h0280, 16'h0100, 16'h0300, 16'h0400, 16'hFF00, 16'h0000};
        int lat, exp_i, exp_lat; logic err, ba; logic [W-1:0] otn, oun, otz, ouz;
        do_clear();
        load_spec_table();
        for (int k = 0; k < 6; k++) begin
            exp_i = model_pair(qs[k]);
            exp_lat = (exp_i < 0) ? 1 : exp_i + 2;
            if (exp_i >= 0) begin
                m_tn = mt[exp_i]; m_un = mu[exp_i]; m_tz = mt[exp_i+1]; m_uz = mu[exp_i+1];
            end
            do_search(qs[k], lat, err, otn, oun, otz, ouz, ba);
            $display("spec search tk=%h latency=%0d error=%b pair=%h/%h %h/%h", qs[k], lat, err, otn, oun, otz, ouz);
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL spec_latency tk=%h got %0d want %0d", qs[k], lat, exp_lat); end
            checks++;
            if (err !== (exp_i < 0)) begin errors++; $display("FAIL spec_error tk=%h got %b want %b", qs[k], err, exp_i < 0); end
            checks++;
            if ({otn, oun, otz, ouz} !== {m_tn, m_un, m_tz, m_uz}) begin
                errors++; $display("FAIL spec_pair tk=%h got %h want %h", qs[k], {otn, oun, otz, ouz}, {m_tn, m_un, m_tz, m_uz});
            end
            checks++;
            if (ba !== 1'b0) begin errors++; $display("FAIL spec_busy_after tk=%h got %b want 0", qs[k], ba); end
        end
    endtask

    task automatic test_wr_err();
        logic werr; int cnt;
        do_write(16'h0200, 16'h1111, werr, cnt);
        $display("append t=0200 after 0300: wr_err=%b count=%0d", werr, cnt);
        checks++;
        if (werr !== 1'b1 || cnt != 4) begin errors++; $display("FAIL nonincreasing_append got wr_err=%b count=%0d want 1/4", werr, cnt); end
        @(posedge clk); #1;
        checks++;
        if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse_width got %b want 0", bus.wr_err); end
        for (int i = 4; i < 9; i++) begin
            logic [W-1:0] t;
            logic exp;
            t = W'((i + 1) * 256);
            exp = !model_accept(t);
            do_write(t, W'(i * 3), werr, cnt);
            if (!exp) begin mt.push_back(t); mu.push_back(W'(i * 3)); end
            $display("fill append t=%h wr_err=%b count=%0d", t, werr, cnt);
            checks++;
            if (werr !== exp || cnt != mt.size()) begin
                errors++; $display("FAIL fill_append[%0d] got wr_err=%b count=%0d want %b/%0d", i, werr, cnt, exp, mt.size());
            end
        end
    endtask

    task automatic test_single_entry();
        int lat; logic err, ba, werr; int cnt; logic [W-1:0] otn, oun, otz, ouz;
        do_clear();
        do_write(16'h0100, 16'h0055, werr, cnt);
        mt.push_back(16'h0100); mu.push_back(16'h0055);
        do_search(16'h0100, lat, err, otn, oun, otz, ouz, ba);
        $display("count=1 search tk=0100 latency=%0d error=%b", lat, err);
        checks++;
        if (lat != 1 || err !== 1'b1) begin errors++; $display("FAIL single_entry got lat=%0d err=%b want 1/1", lat, err); end
        checks++;
        if ({otn, oun, otz, ouz} !== {m_tn, m_un, m_tz, m_uz}) begin
            errors++; $display("FAIL single_entry_hold got %h want %h", {otn, oun, otz, ouz}, {m_tn, m_un, m_tz, m_uz});
        end
    endtask

    task automatic test_busy_write();
        int lat;
        do_clear();
        load_spec_table();
        bus.tk = 16'h0280; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_t = 16'h0400; bus.wr_u = 16'h0800;
        bus.tk = 16'h0000;
        lat = 1;
        @(posedge clk); #1;
        lat++;
        bus.wr_en = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL busy_append wr_err got %b want 1", bus.wr_err); end
        while (bus.done !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
        m_tn = 16'h0200; m_un = 16'h0400; m_tz = 16'h0300; m_uz = 16'h0600;
        $display("busy write/start: latency=%0d pair=%h/%h count=%0d", lat, bus.tn, bus.tz, bus.count);
        checks++;
        if (lat != 4 || bus.error !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got lat=%0d err=%b want 4/0", lat, bus.error); end
        checks++;
        if ({bus.tn, bus.un, bus.tz, bus.uz} !== {m_tn, m_un, m_tz, m_uz}) begin
            errors++; $display("FAIL busy_pair got %h want %h", {bus.tn, bus.un, bus.tz, bus.uz}, {m_tn, m_un, m_tz, m_uz});
        end
        checks++;
        if (bus.count !== 4'd4) begin errors++; $display("FAIL busy_append_count got %0d want 4", bus.count); end
        @(posedge clk); #1;
    endtask

    task automatic test_simul_start_write();
        int lat, cnt; logic err, ba, werr; logic [W-1:0] otn, oun, otz, ouz;
        do_clear();
        do_write(16'h0000, 16'h0010, werr, cnt); mt.push_back(16'h0000); mu.push_back(16'h0010);
        do_write(16'h0100, 16'h0020, werr, cnt); mt.push_back(16'h0100); mu.push_back(16'h0020);
        bus.tk = 16'h0180; bus.start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_t = 16'h0200; bus.wr_u = 16'h0030;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.wr_en = 1'b0;
        $display("simultaneous start/append: done=%b error=%b wr_err=%b count=%0d", bus.done, bus.error, bus.wr_err, bus.count);
        checks++;
        if ({bus.done, bus.error, bus.wr_err} !== 3'b110) begin
            errors++; $display("FAIL simul_old_table got done/err/wr_err=%b want 110", {bus.done, bus.error, bus.wr_err});
        end
        checks++;
        if (bus.count !== 4'd3) begin errors++; $display("FAIL simul_count got %0d want 3", bus.count); end
        mt.push_back(16'h0200); mu.push_back(16'h0030);
        @(posedge clk); #1;
        m_tn = 16'h0100; m_un = 16'h0020; m_tz = 16'h0200; m_uz = 16'h0030;
        do_search(16'h0180, lat, err, otn, oun, otz, ouz, ba);
        checks++;
        if (lat != 3 || err !== 1'b0 || {otn, oun, otz, ouz} !== {m_tn, m_un, m_tz, m_uz}) begin
            errors++; $display("FAIL simul_followup got lat=%0d err=%b pair=%h want 3/0/%h", lat, err, {otn, oun, otz, ouz}, {m_tn, m_un, m_tz, m_uz});
        end
    endtask

    task automatic test_clear_mid_scan();
        int lat; logic err, ba, seen; logic [W-1:0] otn, oun, otz, ouz;
        do_clear();
        load_spec_table();
        bus.tk = 16'h0280; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.clear = 1'b1;
        seen = bus.done;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        mt.delete(); mu.delete();
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        $display("clear mid-scan: done_seen=%b busy=%b count=%0d", seen, bus.busy, bus.count);
        checks++;
        if (seen !== 1'b0 || bus.busy !== 1'b0 || bus.count !== '0) begin
            errors++; $display("FAIL clear_abort got done_seen=%b busy=%b count=%0d want 0/0/0", seen, bus.busy, bus.count);
        end
        do_search(16'h0100, lat, err, otn, oun, otz, ouz, ba);
        checks++;
        if (lat != 1 || err !== 1'b1 || {otn, oun, otz, ouz} !== {m_tn, m_un, m_tz, m_uz}) begin
            errors++; $display("FAIL clear_empty_search got lat=%0d err=%b pair=%h want 1/1/%h", lat, err, {otn, oun, otz, ouz}, {m_tn, m_un, m_tz, m_uz});
        end
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        do_clear();
        load_spec_table();
        bus.tk = 16'h0280; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mt.delete(); mu.delete();
        m_tn = '0; m_un = '0; m_tz = '0; m_uz = '0;
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== '0 || {bus.tn, bus.un, bus.tz, bus.uz} !== 64'h0) begin
            errors++; $display("FAIL async_reset got busy=%b count=%0d pair=%h want 0/0/0", bus.busy, bus.count, {bus.tn, bus.un, bus.tz, bus.uz});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        $display("reset mid-scan: done_seen=%b busy=%b", seen, bus.busy);
        checks++;
        if (seen !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_abort got done_seen=%b busy=%b want 0/0", seen, bus.busy); end
    endtask

    task automatic test_random();
        int lat, exp_i, exp_lat, cnt, n, base, lo, hi; logic err, ba, werr, exp;
        logic [W-1:0] t, u, q, otn, oun, otz, ouz;
        for (int r = 0; r < 25; r++) begin
            do_clear();
            n = $urandom_range(0, 10);
            base = int'($urandom_range(0, 4000)) - 2000;
            for (int i = 0; i < n; i++) begin
                if (mt.size() > 0 && $urandom_range(0, 7) == 0)
                    t = W'(int'($signed(mt[mt.size()-1])) - int'($urandom_range(0, 40)));
                else begin
                    base = base + int'($urandom_range(1, 400));
                    t = W'(base);
                end
                u = W'($urandom);
                exp = !model_accept(t);
                do_write(t, u, werr, cnt);
                if (!exp) begin mt.push_back(t); mu.push_back(u); end
                $display("rand append t=%h u=%h wr_err=%b count=%0d", t, u, werr, cnt);
                checks++;
                if (werr !== exp || cnt != mt.size()) begin
                    errors++; $display("FAIL rand_append t=%h got wr_err=%b count=%0d want %b/%0d", t, werr, cnt, exp, mt.size());
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (mt.size() > 0 && $urandom_range(0, 3) != 0) begin
                    lo = int'($signed(mt[0])) - 60;
                    hi = int'($signed(mt[mt.size()-1])) + 60;
                    q = W'(lo + int'($urandom_range(0, hi - lo)));
                end else if (mt.size() > 0 && k == 3) begin
                    q = mt[$urandom_range(0, mt.size() - 1)];
                end else begin
                    q = W'($urandom);
                end
                exp_i = model_pair(q);
                exp_lat = (exp_i < 0) ? 1 : exp_i + 2;
                if (exp_i >= 0) begin
                    m_tn = mt[exp_i]; m_un = mu[exp_i]; m_tz = mt[exp_i+1]; m_uz = mu[exp_i+1];
                end
                do_search(q, lat, err, otn, oun, otz, ouz, ba);
                $display("rand search tk=%h count=%0d latency=%0d error=%b pair=%h/%h", q, mt.size(), lat, err, otn, otz);
                checks++;
                if (lat != exp_lat || err !== (exp_i < 0)) begin
                    errors++; $display("FAIL rand_timing tk=%h got lat=%0d err=%b want %0d/%b", q, lat, err, exp_lat, exp_i < 0);
                end
                checks++;
                if ({otn, oun, otz, ouz} !== {m_tn, m_un, m_tz, m_uz}) begin
                    errors++; $display("FAIL rand_pair tk=%h got %h want %h", q, {otn, oun, otz, ouz}, {m_tn, m_un, m_tz, m_uz});
                end
            end
        end
    endtask

    initial begin
        bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_t = '0; bus.wr_u = '0;
        bus.start = 1'b0; bus.tk = '0;
        test_reset();
        test_spec_vectors();
        test_wr_err();
        test_single_entry();
        test_busy_write();
        test_simul_start_write();
        test_clear_mid_scan();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
